// File: rtl/buyruk_getir_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch queue entries carry {sikistirilmis, pc, buyruk}.
package buyruk_getir_pkg;

    localparam int unsigned PC_W      = 18;
    localparam int unsigned BUYRUK_W  = 32;
    localparam int unsigned GIRDI_W   = 1 + PC_W + BUYRUK_W;
    localparam logic [1:0]  TAM_DESEN = 2'b11;

    typedef struct packed {
        logic                sikistirilmis;
        logic [PC_W-1:0]     pc;
        logic [BUYRUK_W-1:0] buyruk;
    } kuyruk_girdi_t;

    typedef enum logic {
        GETIR,
        BEKLE_DALLANMA
    } durum_t;

    function automatic logic sikistirilmis_mi(input logic [BUYRUK_W-1:0] w);
        return w[1:0] != TAM_DESEN;
    endfunction

endpackage

// File: rtl/buyruk_kuyrugu.sv
// Small synchronous FIFO between fetch and decode.
// Pointers carry one extra wrap bit to tell full from empty.
module buyruk_kuyrugu
    import buyruk_getir_pkg::*;
#(
    parameter int unsigned KUYRUK_DERINLIK = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          yaz_i,
    input  logic          oku_i,
    input  logic          temizle_i,
    input  kuyruk_girdi_t veri_i,
    output kuyruk_girdi_t veri_o,
    output logic          dolu_o,
    output logic          bos_o
);

    localparam int unsigned IW = $clog2(KUYRUK_DERINLIK);

    kuyruk_girdi_t bellek_q [KUYRUK_DERINLIK];
    logic [IW:0]   yaz_q, yaz_d;
    logic [IW:0]   oku_q, oku_d;

    assign bos_o  = (yaz_q == oku_q);
    assign dolu_o = (yaz_q[IW] != oku_q[IW]) &&
                    (yaz_q[IW-1:0] == oku_q[IW-1:0]);
    assign veri_o = bellek_q[oku_q[IW-1:0]];

    always_comb begin
        yaz_d = yaz_q;
        oku_d = oku_q;
        if (temizle_i) begin
            yaz_d = '0;
            oku_d = '0;
        end else begin
            if (yaz_i && !dolu_o)
                yaz_d = yaz_q + (IW+1)'(1);
            if (oku_i && !bos_o)
                oku_d = oku_q + (IW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_q <= '0;
            oku_q <= '0;
        end else begin
            yaz_q <= yaz_d;
            oku_q <= oku_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!temizle_i && yaz_i && !dolu_o)
            bellek_q[yaz_q[IW-1:0]] <= veri_i;
    end

endmodule

// File: rtl/buyruk_getir.sv
// Instruction fetch: PC in halfwords, 16/32-bit classification,
// redirect handling (including during a cache miss), fetch FIFO.
module buyruk_getir
    import buyruk_getir_pkg::*;
#(
    parameter logic [PC_W-1:0] BASLANGIC_PC    = 18'h0,
    parameter int unsigned     KUYRUK_DERINLIK = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic [PC_W-1:0]     l1b_adres_o,
    input  logic [BUYRUK_W-1:0] l1b_deger_i,
    input  logic                l1b_bekle_i,
    input  logic                dallanma_gecerli_i,
    input  logic [PC_W-1:0]     dallanma_adres_i,
    input  logic                durdur_i,
    output logic [BUYRUK_W-1:0] buyruk_o,
    output logic [PC_W-1:0]     buyruk_pc_o,
    output logic                buyruk_sikistirilmis_o,
    output logic                buyruk_gecerli_o
);

    durum_t          durum_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] bekleyen_adres_q;

    logic          bekleyen_dallanma;
    logic          dolu, bos;
    logic          yakala, cek, sikistirilmis;
    kuyruk_girdi_t yeni, bas;

    assign bekleyen_dallanma = (durum_q == BEKLE_DALLANMA);
    assign sikistirilmis     = sikistirilmis_mi(l1b_deger_i);
    assign yakala = ~l1b_bekle_i & ~dolu &
                    ~dallanma_gecerli_i & ~bekleyen_dallanma;
    assign cek    = ~bos & ~durdur_i;

    always_comb begin
        yeni.sikistirilmis = sikistirilmis;
        yeni.pc            = pc_q;
        yeni.buyruk        = sikistirilmis ?
                             {16'h0, l1b_deger_i[15:0]} : l1b_deger_i;
    end

    buyruk_kuyrugu #(
        .KUYRUK_DERINLIK(KUYRUK_DERINLIK)
    ) u_kuyruk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .yaz_i     (yakala),
        .oku_i     (cek),
        .temizle_i (dallanma_gecerli_i),
        .veri_i    (yeni),
        .veri_o    (bas),
        .dolu_o    (dolu),
        .bos_o     (bos)
    );

    // The PC only moves when the cache is not busy, so the miss
    // address stays stable for the fill FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q          <= GETIR;
            pc_q             <= BASLANGIC_PC;
            bekleyen_adres_q <= '0;
        end else if (dallanma_gecerli_i) begin
            if (l1b_bekle_i) begin
                durum_q          <= BEKLE_DALLANMA;
                bekleyen_adres_q <= dallanma_adres_i;
            end else begin
                durum_q <= GETIR;
                pc_q    <= dallanma_adres_i;
            end
        end else begin
            unique case (durum_q)
                BEKLE_DALLANMA: begin
                    if (!l1b_bekle_i) begin
                        durum_q <= GETIR;
                        pc_q    <= bekleyen_adres_q;
                    end
                end
                GETIR: begin
                    if (yakala)
                        pc_q <= pc_q + (sikistirilmis ? 18'd1 : 18'd2);
                end
                default: durum_q <= GETIR;
            endcase
        end
    end

    assign l1b_adres_o            = pc_q;
    assign buyruk_gecerli_o       = ~bos;
    assign buyruk_o               = bos ? '0 : bas.buyruk;
    assign buyruk_pc_o            = bos ? '0 : bas.pc;
    assign buyruk_sikistirilmis_o = bos ? 1'b0 : bas.sikistirilmis;

endmodule
